// File: rtl/cr_kme_key_tlv_gen.sv
// -----------------------------------------------------------------------------
// cr_kme_key_tlv_gen
//
// Key TLV generator. Turns one key command (tag, word count, error flag) plus
// the unwrapped key data words into one framed TLV on the usr_ob write
// interface: a header word followed by the data words. Output pacing follows
// usr_ob_afull; usr_ob_full is only monitored for protocol violations.
//
// Optional feature (macro CR_KME_KEY_TLV_CHKSUM_EN): appends a trailer word
// holding the XOR of all data words; header length then counts the trailer.
// Error and zero-length TLVs never carry a trailer.
//
// Parameters:
//   TLV_TYPE  type code placed in header bits [63:56]
//   CNT_W     width of the tlv_cnt statistics counter
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/ready          key command handshake
//   cmd_tid/nwords/err       command tag, data word count, error flag
//   kdat_valid/ready/data    key data word handshake
//   usr_ob_wr/data/sot/eot   registered one-cycle write to downstream
//   usr_ob_full/afull        downstream full / almost-full
//   busy                     FSM active or a write in flight
//   tlv_cnt                  completed TLV count (wraps)
//   ovfl_err                 sticky: write issued while downstream full
// -----------------------------------------------------------------------------
module cr_kme_key_tlv_gen #(
  parameter logic [7:0] TLV_TYPE = 8'h0C,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_tid,
  input  logic [3:0]       cmd_nwords,
  input  logic             cmd_err,
  input  logic             kdat_valid,
  output logic             kdat_ready,
  input  logic [63:0]      kdat_data,
  output logic             usr_ob_wr,
  output logic [63:0]      usr_ob_data,
  output logic             usr_ob_sot,
  output logic             usr_ob_eot,
  input  logic             usr_ob_full,
  input  logic             usr_ob_afull,
  output logic             busy,
  output logic [CNT_W-1:0] tlv_cnt,
  output logic             ovfl_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
`ifdef CR_KME_KEY_TLV_CHKSUM_EN
    DATA = 2'd2,
    TRL  = 2'd3
`else
    DATA = 2'd2
`endif
  } state_t;

  state_t           state_r, state_s;
  logic [7:0]       tid_r;
  logic [3:0]       nwords_r;
  logic             err_r;
  logic [3:0]       wcnt_r;
`ifdef CR_KME_KEY_TLV_CHKSUM_EN
  logic [63:0]      xor_r;
`endif
  logic             wr_r, sot_r, eot_r;
  logic [63:0]      data_r;
  logic [CNT_W-1:0] tlv_cnt_r;
  logic             ovfl_r;

  logic             cap_s, acc_s, wr_s, sot_s, eot_s;
  logic [63:0]      data_s;
  logic             short_s, last_s;
  logic [15:0]      len_s;
  logic [63:0]      hdr_s;

  // Header-only TLVs (error or empty) end at the header.
  assign short_s = err_r | (nwords_r == 4'd0);
  // The word being accepted now is the final data word.
  assign last_s  = ((wcnt_r + 4'd1) == nwords_r);

`ifdef CR_KME_KEY_TLV_CHKSUM_EN
  assign len_s = short_s ? 16'd1 : ({12'd0, nwords_r} + 16'd2);
`else
  assign len_s = {12'd0, nwords_r} + 16'd1;
`endif

  assign hdr_s = {TLV_TYPE, tid_r, len_s, 31'd0, err_r};

  // Next-state, handshake and next-write decode.
  always_comb begin
    state_s    = state_r;
    cmd_ready  = 1'b0;
    kdat_ready = 1'b0;
    cap_s      = 1'b0;
    acc_s      = 1'b0;
    wr_s       = 1'b0;
    sot_s      = 1'b0;
    eot_s      = 1'b0;
    data_s     = 64'd0;
    case (state_r)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cap_s   = 1'b1;
          state_s = HDR;
        end else begin
          state_s = IDLE;
        end
      end
      HDR: begin
        if (!usr_ob_afull) begin
          wr_s   = 1'b1;
          sot_s  = 1'b1;
          data_s = hdr_s;
          if (short_s) begin
            eot_s   = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = HDR;
        end
      end
      DATA: begin
        kdat_ready = ~usr_ob_afull;
        if (kdat_valid && !usr_ob_afull) begin
          acc_s  = 1'b1;
          wr_s   = 1'b1;
          data_s = kdat_data;
          if (last_s) begin
`ifdef CR_KME_KEY_TLV_CHKSUM_EN
            state_s = TRL;
`else
            eot_s   = 1'b1;
            state_s = IDLE;
`endif
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef CR_KME_KEY_TLV_CHKSUM_EN
      TRL: begin
        if (!usr_ob_afull) begin
          wr_s    = 1'b1;
          eot_s   = 1'b1;
          data_s  = xor_r;
          state_s = IDLE;
        end else begin
          state_s = TRL;
        end
      end
`endif
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, captured command, output registers and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      tid_r     <= 8'd0;
      nwords_r  <= 4'd0;
      err_r     <= 1'b0;
      wcnt_r    <= 4'd0;
`ifdef CR_KME_KEY_TLV_CHKSUM_EN
      xor_r     <= 64'd0;
`endif
      wr_r      <= 1'b0;
      sot_r     <= 1'b0;
      eot_r     <= 1'b0;
      data_r    <= 64'd0;
      tlv_cnt_r <= {CNT_W{1'b0}};
      ovfl_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      if (cap_s) begin
        tid_r    <= cmd_tid;
        nwords_r <= cmd_nwords;
        err_r    <= cmd_err;
        wcnt_r   <= 4'd0;
`ifdef CR_KME_KEY_TLV_CHKSUM_EN
        xor_r    <= 64'd0;
`endif
      end else if (acc_s) begin
        wcnt_r <= wcnt_r + 4'd1;
`ifdef CR_KME_KEY_TLV_CHKSUM_EN
        xor_r  <= xor_r ^ kdat_data;
`endif
      end
      wr_r   <= wr_s;
      sot_r  <= sot_s;
      eot_r  <= eot_s;
      data_r <= data_s;
      // Count TLVs as their last word is actually presented downstream.
      if (wr_r && eot_r) begin
        tlv_cnt_r <= tlv_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (wr_r && usr_ob_full) begin
        ovfl_r <= 1'b1;
      end
    end
  end

  assign usr_ob_wr   = wr_r;
  assign usr_ob_data = data_r;
  assign usr_ob_sot  = sot_r;
  assign usr_ob_eot  = eot_r;
  assign tlv_cnt     = tlv_cnt_r;
  assign ovfl_err    = ovfl_r;
  assign busy        = (state_r != IDLE) | wr_r;

endmodule

// File: doc/cr_kme_key_tlv_gen.md
Name: cr_kme_key_tlv_gen

Overview:
Key TLV generator that sits directly upstream of the KME key TLV reassembly/AXI4-S output stage. It turns one key command (tag, word count, error flag) plus the unwrapped key data words into one framed TLV word stream on the usr_ob write interface, with a header word followed by the data words. Pacing uses the downstream usr_ob_afull; usr_ob_full is monitored for protocol violations only.

Parameters:
TLV_TYPE, 8'h0C, type code placed in header bits [63:56]
CNT_W, 16, width of the tlv_cnt statistics counter

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  key command valid
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
cmd_tid  input  8  tag copied to header
cmd_nwords  input  4  number of key data words (0..15)
cmd_err  input  1  key fetch/unwrap failed; emit header-only error TLV
kdat_valid  input  1  key data word valid
kdat_ready  output  1  key data word accepted when kdat_valid & kdat_ready
kdat_data  input  64  key data word
usr_ob_wr  output  1  one-cycle write strobe to downstream
usr_ob_data  output  64  TLV word
usr_ob_sot  output  1  first word of TLV
usr_ob_eot  output  1  last word of TLV
usr_ob_full  input  1  downstream full
usr_ob_afull  input  1  downstream almost full
busy  output  1  FSM not in IDLE or a write is in flight
tlv_cnt  output  CNT_W  count of completed TLVs (eot writes), wraps
ovfl_err  output  1  sticky: usr_ob_wr asserted while usr_ob_full

Behaviour:
- Reset: synchronous and active-high. Asserting rst forces the FSM to IDLE and clears all of the following: usr_ob_wr, usr_ob_data, usr_ob_sot, usr_ob_eot, tlv_cnt, ovfl_err and the captured command. Reset asserted mid-TLV abandons the partial TLV with no eot. The downstream stage is reset together with this block.
- All usr_ob_* outputs are registered. A word decided in cycle N appears with usr_ob_wr=1 in cycle N+1 for exactly one cycle.
- FSM has three states: IDLE, HDR and DATA.
- IDLE state:
  - cmd_ready=1 and kdat_ready=0.
  - On cmd_valid, the block captures tid, nwords and err, clears the word counter, and moves to HDR.
- HDR state:
  - cmd_ready=0.
  - If usr_ob_afull=0, the header is issued with sot=1.
  - Header format: [63:56]=TLV_TYPE, [55:48]=tid, [47:32]=nwords+1 (total words including the header), [31:1]=0, [0]=err.
  - If err=1 or nwords=0: eot=1, the FSM returns to IDLE, and no data words are consumed.
  - Otherwise: eot=0 and the FSM moves to DATA.
  - If usr_ob_afull=1, the FSM stalls in HDR.
- DATA state:
  - kdat_ready = ~usr_ob_afull.
  - Each accepted word is written on the next cycle with sot=0, and the counter increments.
  - When the counter reaches nwords, the accepted word carries eot=1 and the FSM returns to IDLE.
  - kdat_valid=0 creates a bubble only; no write is issued.
- Throughput: one word per cycle while afull=0. Back-to-back commands: IDLE costs one cycle between TLVs.
- The write decision uses afull sampled in the same cycle, so at most one write lands after afull rises. The downstream afull threshold must leave at least 2 free entries.
- ovfl_err sets when usr_ob_wr & usr_ob_full, and clears only on rst. The write is still issued.
- tlv_cnt increments on every write with eot=1, modulo 2^CNT_W.
- busy = (state!=IDLE) | usr_ob_wr.
- kdat_valid in IDLE/HDR is ignored: the word is held upstream, not consumed.

Optional Feature:
Macro: CR_KME_KEY_TLV_CHKSUM_EN.
- Defined:
  - A fourth state TRL follows DATA.
  - The header length field becomes nwords+2.
  - The last data word has eot=0.
  - TRL, gated by afull, emits a trailer word with eot=1 equal to the 64-bit XOR of all data words of the TLV.
  - Error and nwords=0 TLVs carry no trailer and keep length 1.
- Undefined: there is no TRL state and no XOR register, and behaviour is exactly as in Behaviour.

Test Plan:
- Command tid=8'h5A, nwords=2, err=0, data 64'h1111…, 64'h2222…, afull=0 -> 3 writes on consecutive cycles; header=64'h0C5A0003_00000000 with sot=1; last data word has eot=1; tlv_cnt=1. With CHKSUM_EN: 4 writes, length=4, trailer=64'h3333_3333_3333_3333.
- cmd_err=1 with nwords=5 -> single write of header 64'h0C??0006_00000001 with sot=eot=1; kdat_ready stays 0; the FSM is back in IDLE 1 cycle after the write.
- afull held high for 10 cycles during DATA -> no usr_ob_wr and kdat_ready=0 throughout; after release the remaining words flow in order with no loss or duplication.
- Force usr_ob_full=1 coincident with a write -> ovfl_err rises next cycle and stays high until rst.
- Assert rst for 1 cycle in DATA after 1 of 4 words -> all outputs 0 next cycle and FSM in IDLE; a following nwords=1 command produces a clean 2-word TLV.
- 65536 consecutive nwords=0 commands with CNT_W=16 -> tlv_cnt wraps to 0; the gap between headers is exactly 1 cycle.
